pc_sequencer: RTL and testbench

//  Program-counter register and sequencing FSM, the consumer of the branch-offset path.

---
 rtl/pc_sequencer.sv | 128 ++++++++++++
 tb/tb_pc_sequencer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter register with IDLE/RUN/DONE sequencing FSM.
// The PC advances by +1 each run cycle, or by a signed relative offset on a
// taken branch. Start, Halt and Done form the program handshake, and Stall
// freezes the PC and the FSM.
//
// Ports:
//   Clk         rising-edge clock
//   Reset_n     asynchronous active-low reset
//   Start       begin program (accepted in IDLE or DONE when not stalled)
//   StartAddr   PC loaded when Start is accepted
//   Stall       freeze PC and FSM this cycle
//   Halt        current instruction is a halt (RUN only)
//   BranchEn    branch taken this cycle (RUN only)
//   Target      signed two's-complement relative branch offset
//   ProgCtr     current PC / instruction-memory address
//   FetchValid  ProgCtr addresses a live instruction (RUN & !Stall)
//   Done        program halted; high for the whole DONE state
//   BranchCnt   taken-branch count
//
// Optional feature: define PC_BRANCH_COUNT_EN to build the taken-branch
// counter. When it is undefined, BranchCnt is tied to zero.
module pc_sequencer #(
  parameter int unsigned D     = 12,
  parameter int unsigned CNT_W = 8
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic [D-1:0]     StartAddr,
  input  logic             Stall,
  input  logic             Halt,
  input  logic             BranchEn,
  input  logic [D-1:0]     Target,
  output logic [D-1:0]     ProgCtr,
  output logic             FetchValid,
  output logic             Done,
  output logic [CNT_W-1:0] BranchCnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [D-1:0]   pc_q, pc_d;
  logic           start_acc;

  // Next-state and next-PC logic. In RUN the priority is Stall > Halt > BranchEn > increment.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    start_acc = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (!Stall && Start) begin
          start_acc = 1'b1;
          state_d   = S_RUN;
          pc_d      = StartAddr;
        end
      end
      S_RUN: begin
        if (!Stall) begin
          if (Halt) begin
            state_d = S_DONE;
          end else if (BranchEn) begin
            // The add wraps modulo 2^D, so a two's-complement Target behaves as a signed offset.
            pc_d = pc_q + Target;
          end else begin
            pc_d = pc_q + D'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and PC registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign ProgCtr    = pc_q;
  assign Done       = (state_q == S_DONE);
  // FetchValid is the only output that depends on a live input (Stall).
  assign FetchValid = (state_q == S_RUN) && !Stall;

`ifdef PC_BRANCH_COUNT_EN
  logic [CNT_W-1:0] bcnt_q, bcnt_d;
  logic             branch_acc;

  // Count only branches that actually redirect the PC.
  always_comb begin
    branch_acc = (state_q == S_RUN) && !Stall && !Halt && BranchEn;
    bcnt_d     = bcnt_q;
    if (start_acc) begin
      bcnt_d = '0;
    end else if (branch_acc) begin
      bcnt_d = bcnt_q + CNT_W'(1);
    end
  end

  // Taken-branch counter register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      bcnt_q <= '0;
    end else begin
      bcnt_q <= bcnt_d;
    end
  end

  assign BranchCnt = bcnt_q;
`else
  logic unused_start_acc;
  assign unused_start_acc = start_acc;
  assign BranchCnt        = '0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer (D=12, CNT_W=8): a directed vector
// table, a mid-run reset sequence, and randomized stimulus checked against a
// behavioural model.
module tb_pc_sequencer;

  localparam int unsigned D     = 12;
  localparam int unsigned CNT_W = 8;
`ifdef PC_BRANCH_COUNT_EN
  localparam bit BC_EN = 1'b1;
`else
  localparam bit BC_EN = 1'b0;
`endif

  logic             Clk = 1'b0;
  logic             Reset_n;
  logic             Start;
  logic [D-1:0]     StartAddr;
  logic             Stall;
  logic             Halt;
  logic             BranchEn;
  logic [D-1:0]     Target;
  logic [D-1:0]     ProgCtr;
  logic             FetchValid;
  logic             Done;
  logic [CNT_W-1:0] BranchCnt;

  int n_cmp  = 0;
  int n_fail = 0;

  pc_sequencer #(.D(D), .CNT_W(CNT_W)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .StartAddr(StartAddr),
    .Stall(Stall), .Halt(Halt), .BranchEn(BranchEn), .Target(Target),
    .ProgCtr(ProgCtr), .FetchValid(FetchValid), .Done(Done), .BranchCnt(BranchCnt)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic        start;
    logic [11:0] addr;
    logic        stall;
    logic        halt;
    logic        br;
    logic [11:0] tgt;
    logic        exp_fv;
    logic [11:0] exp_pc;
    logic        exp_done;
    logic [7:0]  exp_bc;
  } vec_t;

  vec_t tbl[24];

  function automatic vec_t mk(input logic st, input logic [11:0] a, input logic sl,
                              input logic h, input logic b, input logic [11:0] t,
                              input logic fv, input logic [11:0] pc, input logic dn,
                              input logic [7:0] bc);
    vec_t v;
    v.start = st; v.addr = a; v.stall = sl; v.halt = h; v.br = b; v.tgt = t;
    v.exp_fv = fv; v.exp_pc = pc; v.exp_done = dn; v.exp_bc = bc;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic st, input logic [11:0] a, input logic sl,
                       input logic h, input logic b, input logic [11:0] t);
    @(negedge Clk);
    Start = st; StartAddr = a; Stall = sl; Halt = h; BranchEn = b; Target = t;
  endtask

  function automatic int bc_exp(input int x);
    return BC_EN ? x : 0;
  endfunction

  // Behavioural model: 0 = idle, 1 = running, 2 = halted
  int m_state, m_pc, m_bc;

  task automatic model_step(input logic st, input logic [11:0] a, input logic sl,
                            input logic h, input logic b, input logic [11:0] t);
    if (sl) return;
    if (m_state != 1) begin
      if (st) begin m_state = 1; m_pc = int'(a); m_bc = 0; end
    end else if (h) begin
      m_state = 2;
    end else if (b) begin
      m_pc = (m_pc + int'(t)) % 4096;
      m_bc = (m_bc + 1) % 256;
    end else begin
      m_pc = (m_pc + 1) % 4096;
    end
  endtask

  initial begin
    // Directed table: start, increments, signed branches, wrap, stall, halt, restart
    tbl[0]  = mk(1, 12'h010, 0, 0, 0, 12'h000, 0, 12'h010, 0, 0);
    tbl[1]  = mk(0, 12'h000, 0, 0, 0, 12'h000, 1, 12'h011, 0, 0);
    tbl[2]  = mk(0, 12'h000, 0, 0, 0, 12'h000, 1, 12'h012, 0, 0);
    tbl[3]  = mk(0, 12'h000, 0, 0, 0, 12'h000, 1, 12'h013, 0, 0);
    tbl[4]  = mk(0, 12'h000, 0, 0, 1, 12'h06D, 1, 12'h080, 0, 1);
    tbl[5]  = mk(0, 12'h000, 0, 0, 1, 12'hF97, 1, 12'h017, 0, 2);
    tbl[6]  = mk(0, 12'h000, 0, 0, 0, 12'h000, 1, 12'h018, 0, 2);
    tbl[7]  = mk(0, 12'h000, 0, 0, 0, 12'h000, 1, 12'h019, 0, 2);
    tbl[8]  = mk(0, 12'h000, 0, 0, 1, 12'h009, 1, 12'h022, 0, 3);
    tbl[9]  = mk(0, 12'h000, 0, 0, 1, 12'hFDD, 1, 12'hFFF, 0, 4);
    tbl[10] = mk(1, 12'h555, 0, 0, 0, 12'h000, 1, 12'h000, 0, 4);
    tbl[11] = mk(0, 12'h000, 0, 0, 0, 12'h000, 1, 12'h001, 0, 4);
    tbl[12] = mk(0, 12'h000, 0, 0, 0, 12'h000, 1, 12'h002, 0, 4);
    tbl[13] = mk(0, 12'h000, 0, 0, 1, 12'hFFC, 1, 12'hFFE, 0, 5);
    tbl[14] = mk(0, 12'h000, 1, 1, 1, 12'h123, 0, 12'hFFE, 0, 5);
    tbl[15] = mk(0, 12'h000, 1, 1, 1, 12'h123, 0, 12'hFFE, 0, 5);
    tbl[16] = mk(0, 12'h000, 0, 1, 0, 12'h000, 1, 12'hFFE, 1, 5);
    tbl[17] = mk(0, 12'h000, 0, 0, 0, 12'h000, 0, 12'hFFE, 1, 5);
    tbl[18] = mk(1, 12'h040, 1, 0, 0, 12'h000, 0, 12'hFFE, 1, 5);
    tbl[19] = mk(1, 12'h040, 0, 0, 0, 12'h000, 0, 12'h040, 0, 0);
    tbl[20] = mk(1, 12'h100, 0, 1, 0, 12'h000, 1, 12'h040, 1, 0);
    tbl[21] = mk(1, 12'h200, 0, 0, 0, 12'h000, 0, 12'h200, 0, 0);
    tbl[22] = mk(0, 12'h000, 0, 0, 1, 12'h000, 1, 12'h200, 0, 1);
    tbl[23] = mk(1, 12'h300, 0, 0, 0, 12'h000, 1, 12'h201, 0, 1);

    Start = 0; StartAddr = '0; Stall = 0; Halt = 0; BranchEn = 0; Target = '0;
    Reset_n = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    chk("reset_pc", int'(ProgCtr), 0);
    chk("reset_done", int'(Done), 0);
    chk("reset_fv", int'(FetchValid), 0);
    chk("reset_bc", int'(BranchCnt), 0);
    @(negedge Clk);
    Reset_n = 1'b1;

    for (int i = 0; i < 24; i++) begin
      drive(tbl[i].start, tbl[i].addr, tbl[i].stall, tbl[i].halt, tbl[i].br, tbl[i].tgt);
      #1;
      chk($sformatf("vec%0d_fv", i), int'(FetchValid), int'(tbl[i].exp_fv));
      @(posedge Clk);
      #1;
      chk($sformatf("vec%0d_pc", i), int'(ProgCtr), int'(tbl[i].exp_pc));
      chk($sformatf("vec%0d_done", i), int'(Done), int'(tbl[i].exp_done));
      chk($sformatf("vec%0d_bc", i), int'(BranchCnt), bc_exp(int'(tbl[i].exp_bc)));
    end

    // Reset asserted mid-RUN at PC 0x123 takes effect without waiting for a clock edge
    drive(0, 12'h000, 0, 0, 1, 12'hF22);
    @(posedge Clk);
    #1;
    chk("pre_rst_pc", int'(ProgCtr), 'h123);
    drive(0, 12'h000, 0, 0, 0, 12'h000);
    #2;
    Reset_n = 1'b0;
    #1;
    chk("midrst_pc", int'(ProgCtr), 0);
    chk("midrst_done", int'(Done), 0);
    chk("midrst_fv", int'(FetchValid), 0);
    chk("midrst_bc", int'(BranchCnt), 0);
    @(negedge Clk);
    Reset_n = 1'b1;
    drive(0, 12'h000, 0, 0, 0, 12'h000);
    #1;
    chk("post_rst_fv", int'(FetchValid), 0);
    @(posedge Clk);
    #1;
    chk("post_rst_pc", int'(ProgCtr), 0);

    // Randomized run against the behavioural model
    m_state = 0; m_pc = 0; m_bc = 0;
    for (int n = 0; n < 500; n++) begin
      logic st, sl, h, b;
      logic [11:0] a, t;
      st = ($urandom_range(0, 3) == 0);
      sl = ($urandom_range(0, 4) == 0);
      h  = ($urandom_range(0, 15) == 0);
      b  = ($urandom_range(0, 2) == 0);
      a  = 12'($urandom);
      t  = 12'($urandom);
      drive(st, a, sl, h, b, t);
      #1;
      chk("rnd_fv", int'(FetchValid), (m_state == 1 && !sl) ? 1 : 0);
      @(posedge Clk);
      #1;
      model_step(st, a, sl, h, b, t);
      chk("rnd_pc", int'(ProgCtr), m_pc);
      chk("rnd_done", int'(Done), (m_state == 2) ? 1 : 0);
      chk("rnd_bc", int'(BranchCnt), bc_exp(m_bc));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
